// File: rtl/biquad_channel_scheduler.sv
// biquad_channel_scheduler
// One biquad multiply-accumulate engine shared round-robin by NUM_CH channels.
// Each serviced sample takes five MAC steps (b0, b1, b2, a1, a2). The per-channel
// x/y history is swapped in at grant time. All channels share one coefficient set.
module biquad_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH_D = 18,
  parameter int WIDTH_C = 18,
  parameter int SCALING = 0,
  parameter logic signed [WIDTH_C-1:0] COEFF_B0 = '0,
  parameter logic signed [WIDTH_C-1:0] COEFF_B1 = '0,
  parameter logic signed [WIDTH_C-1:0] COEFF_B2 = '0,
  parameter logic signed [WIDTH_C-1:0] COEFF_A1 = '0,
  parameter logic signed [WIDTH_C-1:0] COEFF_A2 = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            chStrobe,
  input  logic [NUM_CH*WIDTH_D-1:0]    chDataIn,
  input  logic                         cfgWe,
  input  logic [2:0]                   cfgAddr,
  input  logic [WIDTH_C-1:0]           cfgData,
  output logic                         cfgReady,
  output logic                         outStrobe,
  output logic [$clog2(NUM_CH)-1:0]    outCh,
  output logic [WIDTH_D-1:0]           dataOut,
  output logic [NUM_CH-1:0]            overrun
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PROD_W = WIDTH_D + WIDTH_C;
  localparam int ACC_W  = PROD_W + 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_B0   = 3'd1;
  localparam logic [2:0] S_B1   = 3'd2;
  localparam logic [2:0] S_B2   = 3'd3;
  localparam logic [2:0] S_A1   = 3'd4;
  localparam logic [2:0] S_A2   = 3'd5;

  logic [2:0]                 state;
  logic [CH_W-1:0]            cur_ch;
  logic [CH_W-1:0]            rr_ptr;
  logic [NUM_CH-1:0]          pending;
  logic [NUM_CH-1:0]          busy;
  logic [NUM_CH-1:0]          eligible;
  logic [NUM_CH-1:0]          take_vec;
  logic [NUM_CH-1:0]          done_vec;
  logic signed [WIDTH_D-1:0]  sample [NUM_CH];
  logic signed [WIDTH_D-1:0]  pend   [NUM_CH];
  logic signed [WIDTH_D-1:0]  x_h    [NUM_CH];
  logic signed [WIDTH_D-1:0]  xd1_h  [NUM_CH];
  logic signed [WIDTH_D-1:0]  xd2_h  [NUM_CH];
  logic signed [WIDTH_D-1:0]  y_h    [NUM_CH];
  logic signed [WIDTH_D-1:0]  yd1_h  [NUM_CH];
  logic signed [WIDTH_C-1:0]  coef   [5];

  logic                       cfg_wr;
  logic                       grant;
  logic [CH_W-1:0]            grant_ch;
  logic signed [WIDTH_D-1:0]  mux_d;
  logic signed [WIDTH_C-1:0]  mux_c;

  // MAC pipeline: operand regs -> product -> accumulator -> writeback
  logic                       s1_valid, s1_first, s1_last;
  logic [CH_W-1:0]            s1_ch;
  logic signed [WIDTH_D-1:0]  mult_a;
  logic signed [WIDTH_C-1:0]  mult_b;
  logic                       s2_valid, s2_first, s2_last;
  logic [CH_W-1:0]            s2_ch;
  logic signed [PROD_W-1:0]   mult_out;
  logic signed [ACC_W-1:0]    acc;
  logic                       s3_done;
  logic [CH_W-1:0]            s3_ch;
  logic signed [WIDTH_D-1:0]  y_slice;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign sample[gi] = chDataIn[gi*WIDTH_D +: WIDTH_D];
  end

  assign cfgReady = (state == S_IDLE);
  assign cfg_wr   = cfgWe && cfgReady;
  assign eligible = pending & ~busy;
  assign y_slice  = acc[SCALING +: WIDTH_D];

  // Round-robin pick starting at rr_ptr; a config write in IDLE blocks the grant
  always_comb begin
    logic [CH_W:0] idx;
    grant    = 1'b0;
    grant_ch = '0;
    idx      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (eligible[idx[CH_W-1:0]]) begin
        grant    = 1'b1;
        grant_ch = idx[CH_W-1:0];
      end
    end
    if (!((state == S_A2) || ((state == S_IDLE) && !cfg_wr))) grant = 1'b0;
  end

  // One-hot views of the channel being granted and the channel being written back
  always_comb begin
    take_vec = '0;
    done_vec = '0;
    if (grant)   take_vec[grant_ch] = 1'b1;
    if (s3_done) done_vec[s3_ch]    = 1'b1;
  end

  // Engine sequencer and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cur_ch <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        S_IDLE:  if (grant) state <= S_B0;
        S_B0:    state <= S_B1;
        S_B1:    state <= S_B2;
        S_B2:    state <= S_A1;
        S_A1:    state <= S_A2;
        S_A2:    state <= grant ? S_B0 : S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (grant) begin
        cur_ch <= grant_ch;
        rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end
    end
  end

  // Sample capture, overrun tracking and per-channel history updates
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      busy    <= '0;
      overrun <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        pend[k]  <= '0;
        x_h[k]   <= '0;
        xd1_h[k] <= '0;
        xd2_h[k] <= '0;
        y_h[k]   <= '0;
        yd1_h[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        // A strobe on the grant edge lands after the grant consumed the old sample
        if (chStrobe[k]) begin
          pend[k]    <= sample[k];
          pending[k] <= 1'b1;
          if (pending[k] && !take_vec[k]) overrun[k] <= 1'b1;
        end else if (take_vec[k]) begin
          pending[k] <= 1'b0;
        end
        if (take_vec[k]) begin
          x_h[k]   <= pend[k];
          xd1_h[k] <= x_h[k];
          xd2_h[k] <= xd1_h[k];
          busy[k]  <= 1'b1;
        end else if (done_vec[k]) begin
          busy[k]  <= 1'b0;
        end
        if (done_vec[k]) begin
          y_h[k]   <= y_slice;
          yd1_h[k] <= y_h[k];
        end
      end
    end
  end

  // Runtime coefficient writes; addresses 5..7 are accepted and ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      coef[0] <= COEFF_B0;
      coef[1] <= COEFF_B1;
      coef[2] <= COEFF_B2;
      coef[3] <= COEFF_A1;
      coef[4] <= COEFF_A2;
    end else if (cfg_wr) begin
      case (cfgAddr)
        3'd0:    coef[0] <= cfgData;
        3'd1:    coef[1] <= cfgData;
        3'd2:    coef[2] <= cfgData;
        3'd3:    coef[3] <= cfgData;
        3'd4:    coef[4] <= cfgData;
        default: ;
      endcase
    end
  end

  // Operand select for the current MAC step; a1/a2 use the two previous outputs
  always_comb begin
    mux_d = x_h[cur_ch];
    mux_c = coef[0];
    case (state)
      S_B1:    begin mux_d = xd1_h[cur_ch]; mux_c = coef[1]; end
      S_B2:    begin mux_d = xd2_h[cur_ch]; mux_c = coef[2]; end
      S_A1:    begin mux_d = y_h[cur_ch];   mux_c = coef[3]; end
      S_A2:    begin mux_d = yd1_h[cur_ch]; mux_c = coef[4]; end
      default: ;
    endcase
  end

  // MAC pipeline; channel tag and step markers travel alongside the data
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_ch     <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_ch     <= '0;
      mult_out  <= '0;
      acc       <= '0;
      s3_done   <= 1'b0;
      s3_ch     <= '0;
      outStrobe <= 1'b0;
      outCh     <= '0;
      dataOut   <= '0;
    end else begin
      s1_valid <= (state != S_IDLE);
      s1_first <= (state == S_B0);
      s1_last  <= (state == S_A2);
      s1_ch    <= cur_ch;
      mult_a   <= mux_d;
      mult_b   <= mux_c;

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_ch    <= s1_ch;
      mult_out <= mult_a * mult_b;

      if (s2_valid) acc <= s2_first ? ACC_W'(mult_out) : acc + ACC_W'(mult_out);
      s3_done <= s2_valid && s2_last;
      s3_ch   <= s2_ch;

      outStrobe <= s3_done;
      if (s3_done) begin
        dataOut <= y_slice;
        outCh   <= s3_ch;
      end
    end
  end

endmodule

// File: tb/tb_biquad_channel_scheduler.sv
// Self-checking bench for biquad_channel_scheduler: directed scenarios plus a
// randomized run checked against a plain-arithmetic filter model.
// The DUT uses SCALING=8, so a coefficient of 256 is unity gain.
module tb_biquad_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int WD     = 18;
  localparam int WC     = 18;
  localparam int SC     = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       chStrobe = '0;
  logic [NUM_CH*WD-1:0]    chDataIn = '0;
  logic                    cfgWe = 1'b0;
  logic [2:0]              cfgAddr = '0;
  logic [WC-1:0]           cfgData = '0;
  logic                    cfgReady;
  logic                    outStrobe;
  logic [1:0]              outCh;
  logic [WD-1:0]           dataOut;
  logic [NUM_CH-1:0]       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {int t; int ch; int data;} ev_t;
  ev_t evq[$];

  // Behavioural filter model state
  longint cm[5];
  longint mx1[NUM_CH], mx2[NUM_CH], my1[NUM_CH], my2[NUM_CH];

  biquad_channel_scheduler #(
    .NUM_CH(NUM_CH), .WIDTH_D(WD), .WIDTH_C(WC), .SCALING(SC)
  ) dut (
    .clk(clk), .rst(rst), .chStrobe(chStrobe), .chDataIn(chDataIn),
    .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgData(cfgData), .cfgReady(cfgReady),
    .outStrobe(outStrobe), .outCh(outCh), .dataOut(dataOut), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: one line per output transaction
  always @(negedge clk) begin
    if (outStrobe === 1'b1) begin
      evq.push_back('{cyc, int'(outCh), int'($signed(dataOut))});
      $display("out t=%0d ch=%0d data=%0d", cyc, outCh, $signed(dataOut));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int model_step(input int ch, input int xin);
    longint a;
    longint sh;
    logic signed [WD-1:0] yv;
    a  = cm[0]*xin + cm[1]*mx1[ch] + cm[2]*mx2[ch] + cm[3]*my1[ch] + cm[4]*my2[ch];
    sh = a >>> SC;
    yv = sh[WD-1:0];
    mx2[ch] = mx1[ch];
    mx1[ch] = xin;
    my2[ch] = my1[ch];
    my1[ch] = longint'(yv);
    return int'(yv);
  endfunction

  // All tasks start and end at a falling edge
  task automatic do_reset();
    rst = 1'b1; chStrobe = '0; cfgWe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    evq.delete();
    for (int i = 0; i < 5; i++) cm[i] = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0;
    end
  endtask

  task automatic write_coef(input int a, input int d);
    cfgWe = 1'b1; cfgAddr = 3'(a); cfgData = WC'(d);
    for (int i = 0; i < 100 && cfgReady !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (cfgReady !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_accept got cfgReady=%b want 1", cfgReady);
    end
    @(negedge clk);
    cfgWe = 1'b0;
    if (a < 5) cm[a] = d;
    $display("cfg addr=%0d data=%0d", a, d);
  endtask

  // Single-channel strobe; n returns the edge index that sampled it
  task automatic strobe_ch(input int ch, input int data, output int n);
    chStrobe = '0;
    chStrobe[ch] = 1'b1;
    chDataIn[ch*WD +: WD] = WD'(data);
    @(negedge clk);
    n = cyc;
    chStrobe = '0;
  endtask

  task automatic wait_ev(input int limit, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{0, 0, 0};
    for (int i = 0; i < limit && evq.size() == 0; i++) @(negedge clk);
    if (evq.size() > 0) begin
      e  = evq.pop_front();
      ok = 1'b1;
    end else begin
      n_checks++; n_fail++;
      $display("FAIL out_timeout got none want an output within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (outStrobe !== 1'b0) begin n_fail++; $display("FAIL rst_outStrobe got %b want 0", outStrobe); end
    n_checks++; if (dataOut !== '0) begin n_fail++; $display("FAIL rst_dataOut got %0d want 0", dataOut); end
    n_checks++; if (overrun !== '0) begin n_fail++; $display("FAIL rst_overrun got %b want 0", overrun); end
    n_checks++; if (cfgReady !== 1'b1) begin n_fail++; $display("FAIL rst_cfgReady got %b want 1", cfgReady); end
    n_checks++; if (outCh !== '0) begin n_fail++; $display("FAIL rst_outCh got %0d want 0", outCh); end
  endtask

  task automatic test_passthrough();
    int n; ev_t e; bit ok;
    do_reset();
    write_coef(0, 256);
    strobe_ch(0, 1234, n);
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.t !== n + 9) begin n_fail++; $display("FAIL pt_latency got %0d want %0d", e.t, n + 9); end
      n_checks++; if (e.ch !== 0) begin n_fail++; $display("FAIL pt_ch got %0d want 0", e.ch); end
      n_checks++; if (e.data !== 1234) begin n_fail++; $display("FAIL pt_data got %0d want 1234", e.data); end
    end
    // Address 5 must not disturb the coefficient set
    write_coef(5, 999);
    strobe_ch(0, -321, n);
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.data !== -321) begin n_fail++; $display("FAIL pt_addr5 got %0d want -321", e.data); end
    end
  endtask

  task automatic test_recursion();
    int n; ev_t e; bit ok;
    do_reset();
    write_coef(0, 256);
    write_coef(3, 128);
    for (int k = 0; k < 4; k++) begin
      strobe_ch(1, (k == 0) ? 1024 : 0, n);
      wait_ev(20, e, ok);
      if (ok) begin
        n_checks++; if (e.ch !== 1) begin n_fail++; $display("FAIL rec_ch%0d got %0d want 1", k, e.ch); end
        n_checks++; if (e.data !== (1024 >> k)) begin n_fail++; $display("FAIL rec_data%0d got %0d want %0d", k, e.data, 1024 >> k); end
      end
    end
  endtask

  task automatic test_contention();
    int n; ev_t e; bit ok;
    do_reset();
    write_coef(0, 256);
    chStrobe = 4'b0011;
    chDataIn[0*WD +: WD] = WD'(100);
    chDataIn[1*WD +: WD] = WD'(200);
    @(negedge clk);
    n = cyc;
    chStrobe = '0;
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.t !== n + 9 || e.ch !== 0 || e.data !== 100) begin n_fail++; $display("FAIL cont_first got t=%0d ch=%0d d=%0d want t=%0d ch=0 d=100", e.t, e.ch, e.data, n + 9); end
    end
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.t !== n + 14 || e.ch !== 1 || e.data !== 200) begin n_fail++; $display("FAIL cont_second got t=%0d ch=%0d d=%0d want t=%0d ch=1 d=200", e.t, e.ch, e.data, n + 14); end
    end
    // b1 = unity exposes each channel's own previous input
    write_coef(1, 256);
    strobe_ch(1, 0, n);
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.data !== 200) begin n_fail++; $display("FAIL cont_hist1 got %0d want 200", e.data); end
    end
    strobe_ch(0, 0, n);
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.data !== 100) begin n_fail++; $display("FAIL cont_hist0 got %0d want 100", e.data); end
    end
  endtask

  task automatic test_overrun();
    int n, n2, n3; ev_t e; bit ok;
    do_reset();
    write_coef(0, 256);
    strobe_ch(0, 5, n);
    strobe_ch(2, 7, n2);
    strobe_ch(2, 9, n3);
    n_checks++; if (overrun !== 4'b0100) begin n_fail++; $display("FAIL ovr_flag got %b want 0100", overrun); end
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.ch !== 0 || e.data !== 5) begin n_fail++; $display("FAIL ovr_ch0 got ch=%0d d=%0d want ch=0 d=5", e.ch, e.data); end
    end
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.t !== n + 14 || e.ch !== 2 || e.data !== 9) begin n_fail++; $display("FAIL ovr_ch2 got t=%0d ch=%0d d=%0d want t=%0d ch=2 d=9", e.t, e.ch, e.data, n + 14); end
    end
    repeat (20) @(negedge clk);
    n_checks++; if (evq.size() !== 0) begin n_fail++; $display("FAIL ovr_extra got %0d outputs want 0", evq.size()); end
    n_checks++; if (overrun !== 4'b0100) begin n_fail++; $display("FAIL ovr_sticky got %b want 0100", overrun); end
    do_reset();
    n_checks++; if (overrun !== '0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_config_abort();
    int n, t_acc; ev_t e; bit ok;
    do_reset();
    write_coef(0, 256);
    strobe_ch(3, 50, n);
    repeat (2) @(negedge clk);
    cfgWe = 1'b1; cfgAddr = 3'd0; cfgData = WC'(512);
    n_checks++; if (cfgReady !== 1'b0) begin n_fail++; $display("FAIL cfg_busy got cfgReady=%b want 0", cfgReady); end
    t_acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (cfgReady === 1'b1) begin t_acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cfgWe = 1'b0;
    cm[0] = 512;
    n_checks++; if (t_acc !== n + 6) begin n_fail++; $display("FAIL cfg_ready_back got t=%0d want %0d", t_acc, n + 6); end
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.ch !== 3 || e.data !== 50) begin n_fail++; $display("FAIL cfg_inflight got ch=%0d d=%0d want ch=3 d=50", e.ch, e.data); end
    end
    strobe_ch(3, 10, n);
    wait_ev(20, e, ok);
    if (ok) begin
      n_checks++; if (e.data !== 20) begin n_fail++; $display("FAIL cfg_applied got %0d want 20", e.data); end
    end
    // Reset while the engine sits in A1
    strobe_ch(0, 77, n);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (dataOut !== '0) begin n_fail++; $display("FAIL abort_dataOut got %0d want 0", dataOut); end
    repeat (15) @(negedge clk);
    n_checks++; if (evq.size() !== 0) begin n_fail++; $display("FAIL abort_strobe got %0d outputs want 0", evq.size()); end
  endtask

  task automatic test_random();
    int expq[NUM_CH][$];
    logic [NUM_CH-1:0] m;
    logic signed [WD-1:0] r;
    ev_t e;
    int d;
    do_reset();
    for (int a = 0; a < 5; a++) begin
      r = WD'($urandom);
      write_coef(a, int'(r));
    end
    for (int round = 0; round < 15; round++) begin
      if (round % 5 == 4) begin
        r = WD'($urandom);
        write_coef(int'($urandom_range(0, 4)), int'(r));
      end
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      chStrobe = m;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (m[ch]) begin
          r = WD'($urandom);
          chDataIn[ch*WD +: WD] = r;
          expq[ch].push_back(model_step(ch, int'(r)));
        end
      end
      @(negedge clk);
      chStrobe = '0;
      repeat (30) @(negedge clk);
      while (evq.size() > 0) begin
        e = evq.pop_front();
        n_checks++;
        if (expq[e.ch].size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra got output on ch%0d d=%0d want none", e.ch, e.data);
        end else begin
          d = expq[e.ch].pop_front();
          if (e.data !== d) begin
            n_fail++;
            $display("FAIL rnd_data ch%0d got %0d want %0d", e.ch, e.data, d);
          end
        end
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      n_checks++;
      if (expq[ch].size() != 0) begin
        n_fail++;
        $display("FAIL rnd_missing ch%0d got %0d unserviced want 0", ch, expq[ch].size());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_recursion();
    test_contention();
    test_overrun();
    test_config_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
